data_frame_parser: RTL and testbench
====================================

Name: data_frame_parser

Overview:
- Receiving end of the 64-bit trigger data-frame stream: header word, N data words, footer word.
- Validates framing, strips header/footer and forwards data words with a last-beat marker.
- Reassembles channel ID, 48-bit timestamp and frame length into a per-frame info record.
- Sits after the read side of the frame-generator FIFOs, feeding downstream DMA/readout logic; flags and counts malformed frames.

Parameters:
- CHANNEL_ID, 0, expected channel ID in header/footer [55:48].
- CHECK_CHANNEL, 1, 1 = channel mismatch is an error and the frame is discarded; 0 = any channel accepted.
- MAX_FRAME_LENGTH, 200, maximum legal data-word count N.
- FRAME_LEN_WIDTH, 8, width of the length field.
- TIME_STAMP_WIDTH, 48, full timestamp width.
- FIRST_TIME_STAMP_WIDTH, 24, timestamp bits carried in the header (upper part).
- HEADER_ID, 8'hAA, header marker in [63:56].
- FOOTER_ID, 8'h55, footer marker in [63:56].

Ports:
- CLK  in  1  single clock.
- RESETN  in  1  asynchronous, active-low reset.
- iVALID  in  1  upstream word valid.
- oREADY  out  1  parser accepts the word this cycle.
- DIN  in  64  frame word.
- iREADY  in  1  downstream ready.
- oVALID  out  1  data word valid.
- DOUT  out  64  data word.
- oLAST  out  1  qualifies the last data word of a frame.
- INFO_VALID  out  1  one-cycle pulse: good frame completed.
- INFO_CH_ID  out  8  channel ID of the last good frame.
- INFO_TIMESTAMP  out  48  {header[47:24], footer[47:24]}.
- INFO_LEN  out  8  data-word count N.
- ERR_HEADER  out  1  pulse: non-header word dropped while in IDLE.
- ERR_CHANNEL  out  1  pulse: channel mismatch.
- ERR_LENGTH  out  1  pulse: N > MAX_FRAME_LENGTH.
- ERR_FOOTER  out  1  pulse: bad footer ID, channel or length echo.
- DROP_CNT  out  16  words dropped in IDLE; saturates at 16'hFFFF.

Behaviour:
- Frame word formats:
  - Header: [63:56]=HEADER_ID, [55:48]=channel, [47:24]=timestamp[47:24], [23:16]=N, [15:0] ignored.
  - Footer: [63:56]=FOOTER_ID, [55:48]=channel, [47:24]=timestamp[23:0], [23:16]=N echo, [15:0] ignored.
  - Data words are opaque.
- Reset (async, RESETN=0):
  - State goes to IDLE; all outputs go to 0, including INFO_* and DROP_CNT.
  - Any in-flight frame is lost; no INFO or error pulse is generated for it.
- Handshake:
  - A word transfers when iVALID & oREADY.
  - Output transfers when oVALID & iREADY.
  - DOUT/oLAST are held stable while oVALID & ~iREADY.
- Output buffering:
  - One output register.
  - In DATA, oREADY = ~oVALID | iREADY, giving full throughput and latency 1 (DIN accepted at cycle t appears on DOUT at t+1).
  - In IDLE, FOOTER and DISCARD, oREADY = 1; the output register drains independently.
- State machine (states IDLE, DATA, FOOTER, DISCARD; down-counter `cnt`, FRAME_LEN_WIDTH+1 bits):
  - IDLE, accepted word with [63:56] != HEADER_ID: drop it, pulse ERR_HEADER, DROP_CNT+1.
  - IDLE, valid header, N > MAX_FRAME_LENGTH: pulse ERR_LENGTH, stay in IDLE; the following words resync via the header-drop path.
  - IDLE, valid header, channel mismatch with CHECK_CHANNEL=1: pulse ERR_CHANNEL, cnt=N+1, go to DISCARD.
  - IDLE, other valid header: latch channel, timestamp-high and N; cnt=N; go to DATA, or to FOOTER if N=0.
  - DATA: each accepted word loads the output register and decrements cnt. The word taken at cnt=1 sets oLAST, and the state goes to FOOTER.
  - FOOTER, footer ID, channel and N echo all match: INFO_* update and INFO_VALID pulses on the next cycle.
  - FOOTER, any mismatch: pulse ERR_FOOTER, INFO unchanged.
  - FOOTER always returns to IDLE.
  - DISCARD: consume cnt words with no output, then return to IDLE.
- Data forwarded before a bad footer is not recalled; ERR_FOOTER flags it.
- All pulses are registered, one cycle after the causing transfer.
- Simultaneous events:
  - Footer accepted while the output register still holds the last word: allowed. INFO_VALID may precede the oLAST handshake.
  - Output drain and new load in the same cycle: allowed.

Decomposition:
- Package data_frame_pkg holds:
  - HEADER_ID and FOOTER_ID.
  - Field bit positions (ID, channel, timestamp, length).
  - State enum.
  - Shared by generator-side test models.
- No sub-module needed. The output register may be a small local skid stage, frame_out_reg.

Test Plan:
- Header(ch0, ts_hi=0x123456, N=3), 3 data words, footer(ch0, ts_lo=0xABCDEF, N=3), iREADY=1 -> 3 beats at latency 1, oLAST on beat 3; INFO_VALID once with TIMESTAMP=0x123456ABCDEF, LEN=3.
- Same frame with iREADY toggling 0/1 each cycle -> DOUT stable while stalled; no word lost or duplicated; oLAST only on beat 3.
- Two garbage words, then a good N=1 frame -> ERR_HEADER twice, DROP_CNT=2, then normal frame output.
- Header with channel 5, CHECK_CHANNEL=1, N=2 -> ERR_CHANNEL; 3 words consumed with oVALID never 1; next frame parsed normally.
- Header N=201 -> ERR_LENGTH. Good frame whose footer echoes N=2 for N=3 -> ERR_FOOTER, no INFO_VALID.
- RESETN low mid-DATA (after 1 of 3 words) -> all outputs 0 immediately; a fresh header after release is parsed correctly.

Source files
------------

// File: rtl/data_frame_pkg.sv
// data_frame_pkg: frame word markers, field positions and parser states
package data_frame_pkg;
  localparam logic [7:0] HEADER_ID = 8'hAA;
  localparam logic [7:0] FOOTER_ID = 8'h55;
  localparam int ID_LSB = 56;
  localparam int CH_LSB = 48;
  localparam int TS_LSB = 24;
  localparam int LEN_LSB = 16;
  typedef enum logic [1:0] {IDLE, DATA, FOOTER, DISCARD} stateT;
endpackage

// File: rtl/data_frame_parser.sv
// data_frame_parser: strips header/footer from 64-bit frames, forwards data
// words with a last marker and reports per-frame info and framing errors
module data_frame_parser
  import data_frame_pkg::*;
#(
  parameter logic [7:0] CHANNEL_ID = 8'd0,
  parameter bit CHECK_CHANNEL = 1'b1,
  parameter int MAX_FRAME_LENGTH = 200,
  parameter int FRAME_LEN_WIDTH = 8,
  parameter int TIME_STAMP_WIDTH = 48,
  parameter int FIRST_TIME_STAMP_WIDTH = 24,
  parameter logic [7:0] HEADER_ID = data_frame_pkg::HEADER_ID,
  parameter logic [7:0] FOOTER_ID = data_frame_pkg::FOOTER_ID
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic iVALID,
  output logic oREADY,
  input  logic [63:0] DIN,
  input  logic iREADY,
  output logic oVALID,
  output logic [63:0] DOUT,
  output logic oLAST,
  output logic INFO_VALID,
  output logic [7:0] INFO_CH_ID,
  output logic [TIME_STAMP_WIDTH-1:0] INFO_TIMESTAMP,
  output logic [FRAME_LEN_WIDTH-1:0] INFO_LEN,
  output logic ERR_HEADER,
  output logic ERR_CHANNEL,
  output logic ERR_LENGTH,
  output logic ERR_FOOTER,
  output logic [15:0] DROP_CNT
);
  localparam int CW = FRAME_LEN_WIDTH + 1;
  localparam int LW = TIME_STAMP_WIDTH - FIRST_TIME_STAMP_WIDTH;
  localparam logic [FRAME_LEN_WIDTH-1:0] MAX_LEN = FRAME_LEN_WIDTH'(MAX_FRAME_LENGTH);
  stateT state;
  logic [CW-1:0] cnt;
  logic [7:0] chLat;
  logic [FIRST_TIME_STAMP_WIDTH-1:0] tsHi;
  logic [FRAME_LEN_WIDTH-1:0] lenLat;
  logic xfer;
  logic [7:0] wordId, wordCh;
  logic [FRAME_LEN_WIDTH-1:0] wordLen;
  assign wordId = DIN[ID_LSB +: 8];
  assign wordCh = DIN[CH_LSB +: 8];
  assign wordLen = DIN[LEN_LSB +: FRAME_LEN_WIDTH];
  // Only DATA words need the output register; every other word is consumed in place
  assign oREADY = (state == DATA) ? (~oVALID | iREADY) : 1'b1;
  assign xfer = iVALID & oREADY;
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= IDLE;
      cnt <= '0;
      chLat <= '0;
      tsHi <= '0;
      lenLat <= '0;
      oVALID <= 1'b0;
      DOUT <= '0;
      oLAST <= 1'b0;
      INFO_VALID <= 1'b0;
      INFO_CH_ID <= '0;
      INFO_TIMESTAMP <= '0;
      INFO_LEN <= '0;
      ERR_HEADER <= 1'b0;
      ERR_CHANNEL <= 1'b0;
      ERR_LENGTH <= 1'b0;
      ERR_FOOTER <= 1'b0;
      DROP_CNT <= '0;
    end else begin
      INFO_VALID <= 1'b0;
      ERR_HEADER <= 1'b0;
      ERR_CHANNEL <= 1'b0;
      ERR_LENGTH <= 1'b0;
      ERR_FOOTER <= 1'b0;
      if (oVALID && iREADY) begin
        oVALID <= 1'b0;
        oLAST <= 1'b0;
      end
      if (xfer) begin
        case (state)
          IDLE: begin
            if (wordId != HEADER_ID) begin
              ERR_HEADER <= 1'b1;
              DROP_CNT <= (DROP_CNT == 16'hFFFF) ? DROP_CNT : DROP_CNT + 16'd1;
            end else if (wordLen > MAX_LEN) begin
              ERR_LENGTH <= 1'b1;
            end else if (CHECK_CHANNEL && wordCh != CHANNEL_ID) begin
              ERR_CHANNEL <= 1'b1;
              cnt <= {1'b0, wordLen} + CW'(1);
              state <= DISCARD;
            end else begin
              chLat <= wordCh;
              tsHi <= DIN[TS_LSB +: FIRST_TIME_STAMP_WIDTH];
              lenLat <= wordLen;
              cnt <= {1'b0, wordLen};
              state <= (wordLen == '0) ? FOOTER : DATA;
            end
          end
          DATA: begin
            DOUT <= DIN;
            oVALID <= 1'b1;
            oLAST <= (cnt == CW'(1));
            cnt <= cnt - CW'(1);
            state <= (cnt == CW'(1)) ? FOOTER : DATA;
          end
          FOOTER: begin
            if (wordId == FOOTER_ID && wordCh == chLat && wordLen == lenLat) begin
              INFO_VALID <= 1'b1;
              INFO_CH_ID <= chLat;
              INFO_TIMESTAMP <= {tsHi, DIN[TS_LSB +: LW]};
              INFO_LEN <= lenLat;
            end else begin
              ERR_FOOTER <= 1'b1;
            end
            state <= IDLE;
          end
          default: begin
            cnt <= cnt - CW'(1);
            state <= (cnt == CW'(1)) ? IDLE : DISCARD;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_data_frame_parser.sv
// tb_data_frame_parser: directed checks of framing, flow control, errors and reset
module tb_data_frame_parser;
  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  logic iVALID = 1'b0;
  logic oREADY;
  logic [63:0] DIN = '0;
  logic iREADY = 1'b1;
  logic oVALID;
  logic [63:0] DOUT;
  logic oLAST;
  logic INFO_VALID;
  logic [7:0] INFO_CH_ID;
  logic [47:0] INFO_TIMESTAMP;
  logic [7:0] INFO_LEN;
  logic ERR_HEADER, ERR_CHANNEL, ERR_LENGTH, ERR_FOOTER;
  logic [15:0] DROP_CNT;
  int vectors = 0;
  int miscompares = 0;
  logic [63:0] txq[$];
  logic [63:0] rxData[$];
  logic rxLast[$];
  int sent, infoCnt, errH, errC, errL, errF, stallBad, ovSeen;

  data_frame_parser dut (
    .CLK(CLK), .RESETN(RESETN), .iVALID(iVALID), .oREADY(oREADY), .DIN(DIN),
    .iREADY(iREADY), .oVALID(oVALID), .DOUT(DOUT), .oLAST(oLAST),
    .INFO_VALID(INFO_VALID), .INFO_CH_ID(INFO_CH_ID), .INFO_TIMESTAMP(INFO_TIMESTAMP),
    .INFO_LEN(INFO_LEN), .ERR_HEADER(ERR_HEADER), .ERR_CHANNEL(ERR_CHANNEL),
    .ERR_LENGTH(ERR_LENGTH), .ERR_FOOTER(ERR_FOOTER), .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] hdr(input logic [7:0] ch, input logic [23:0] ts, input logic [7:0] n);
    return {8'hAA, ch, ts, n, 16'h0};
  endfunction

  function automatic logic [63:0] ftr(input logic [7:0] ch, input logic [23:0] ts, input logic [7:0] n);
    return {8'h55, ch, ts, n, 16'h0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Streams txq through the DUT and records every output handshake and pulse
  task automatic run(input bit toggle, input int budget);
    logic hsIn, hsOut, held, prevL;
    logic [63:0] prevD;
    sent = 0; infoCnt = 0; errH = 0; errC = 0; errL = 0; errF = 0; stallBad = 0; ovSeen = 0;
    rxData.delete();
    rxLast.delete();
    for (int c = 0; c < budget; c++) begin
      iREADY = toggle ? c[0] : 1'b1;
      iVALID = sent < txq.size();
      DIN = iVALID ? txq[sent] : 64'h0;
      #1;
      hsIn = iVALID & oREADY;
      hsOut = oVALID & iREADY;
      held = oVALID & ~iREADY;
      prevD = DOUT;
      prevL = oLAST;
      if (hsOut) begin
        rxData.push_back(DOUT);
        rxLast.push_back(oLAST);
      end
      @(posedge CLK);
      #1;
      if (hsIn) sent++;
      if (held && (!oVALID || DOUT !== prevD || oLAST !== prevL)) stallBad++;
      infoCnt += int'(INFO_VALID);
      errH += int'(ERR_HEADER);
      errC += int'(ERR_CHANNEL);
      errL += int'(ERR_LENGTH);
      errF += int'(ERR_FOOTER);
      ovSeen += int'(oVALID);
    end
    iVALID = 1'b0;
    iREADY = 1'b1;
  endtask

  initial begin
    #2;
    chk("reset_ovalid", 64'(oVALID), 64'h0);
    chk("reset_oready", 64'(oREADY), 64'h1);
    chk("reset_ts", 64'(INFO_TIMESTAMP), 64'h0);
    chk("reset_drop", 64'(DROP_CNT), 64'h0);
    tick();
    tick();
    RESETN = 1'b1;
    // Frame 1: latency-1 forwarding with iREADY held high
    iVALID = 1'b1;
    DIN = hdr(8'h00, 24'h123456, 8'd3);
    tick();
    chk("f1_hdr_noout", 64'(oVALID), 64'h0);
    DIN = 64'h1111_0000_0000_0001;
    tick();
    chk("f1_b1_valid", 64'(oVALID), 64'h1);
    chk("f1_b1_data", DOUT, 64'h1111_0000_0000_0001);
    chk("f1_b1_last", 64'(oLAST), 64'h0);
    DIN = 64'h2222_0000_0000_0002;
    tick();
    chk("f1_b2_data", DOUT, 64'h2222_0000_0000_0002);
    DIN = 64'h3333_0000_0000_0003;
    tick();
    chk("f1_b3_data", DOUT, 64'h3333_0000_0000_0003);
    chk("f1_b3_last", 64'(oLAST), 64'h1);
    DIN = ftr(8'h00, 24'hABCDEF, 8'd3);
    tick();
    iVALID = 1'b0;
    chk("f1_info_valid", 64'(INFO_VALID), 64'h1);
    chk("f1_info_ts", 64'(INFO_TIMESTAMP), 64'h0000_1234_56AB_CDEF);
    chk("f1_info_len", 64'(INFO_LEN), 64'd3);
    chk("f1_info_ch", 64'(INFO_CH_ID), 64'h0);
    chk("f1_drained", 64'(oVALID), 64'h0);
    tick();
    chk("f1_info_pulse", 64'(INFO_VALID), 64'h0);
    // Frame 2: same frame under alternating back-pressure
    txq = '{hdr(8'h00, 24'h123456, 8'd3), 64'hA1, 64'hA2, 64'hA3, ftr(8'h00, 24'hABCDEF, 8'd3)};
    run(1'b1, 24);
    chk("f2_sent", 64'(sent), 64'd5);
    chk("f2_beats", 64'(rxData.size()), 64'd3);
    if (rxData.size() == 3) begin
      chk("f2_d0", rxData[0], 64'hA1);
      chk("f2_d1", rxData[1], 64'hA2);
      chk("f2_d2", rxData[2], 64'hA3);
      chk("f2_last", 64'({rxLast[0], rxLast[1], rxLast[2]}), 64'b001);
    end
    chk("f2_stable", 64'(stallBad), 64'd0);
    chk("f2_info", 64'(infoCnt), 64'd1);
    // Two garbage words, then a one-word frame
    txq = '{64'h0123_4567_89AB_CDEF, 64'h5500_0000_0000_0000, hdr(8'h00, 24'h000001, 8'd1),
            64'hBEEF, ftr(8'h00, 24'h000002, 8'd1)};
    run(1'b0, 10);
    chk("g_errh", 64'(errH), 64'd2);
    chk("g_drop", 64'(DROP_CNT), 64'd2);
    chk("g_beats", 64'(rxData.size()), 64'd1);
    if (rxData.size() == 1) begin
      chk("g_data", rxData[0], 64'hBEEF);
      chk("g_last", 64'(rxLast[0]), 64'h1);
    end
    chk("g_info", 64'(infoCnt), 64'd1);
    chk("g_ts", 64'(INFO_TIMESTAMP), 64'h0000_0000_0100_0002);
    // Wrong channel: whole frame discarded without output
    txq = '{hdr(8'h05, 24'h0, 8'd2), 64'hC1, 64'hC2, ftr(8'h05, 24'h0, 8'd2)};
    run(1'b0, 8);
    chk("c_errc", 64'(errC), 64'd1);
    chk("c_nooutput", 64'(ovSeen), 64'd0);
    chk("c_errh", 64'(errH), 64'd0);
    txq = '{hdr(8'h00, 24'h0, 8'd1), 64'hD1, ftr(8'h00, 24'h0, 8'd1)};
    run(1'b0, 6);
    chk("c_next_beats", 64'(rxData.size()), 64'd1);
    chk("c_next_info", 64'(infoCnt), 64'd1);
    chk("c_next_len", 64'(INFO_LEN), 64'd1);
    // Over-long header, then a frame with a bad length echo
    txq = '{hdr(8'h00, 24'h0, 8'd201)};
    run(1'b0, 3);
    chk("l_errl", 64'(errL), 64'd1);
    chk("l_errh", 64'(errH), 64'd0);
    txq = '{hdr(8'h00, 24'h777777, 8'd3), 64'hE1, 64'hE2, 64'hE3, ftr(8'h00, 24'h888888, 8'd2)};
    run(1'b0, 9);
    chk("fb_errf", 64'(errF), 64'd1);
    chk("fb_noinfo", 64'(infoCnt), 64'd0);
    chk("fb_beats", 64'(rxData.size()), 64'd3);
    chk("fb_len_kept", 64'(INFO_LEN), 64'd1);
    // Reset in the middle of a frame
    iVALID = 1'b1;
    DIN = hdr(8'h00, 24'h0A0B0C, 8'd3);
    tick();
    DIN = 64'hF1;
    tick();
    iVALID = 1'b0;
    chk("r_pre_valid", 64'(oVALID), 64'h1);
    RESETN = 1'b0;
    #1;
    chk("r_ovalid", 64'(oVALID), 64'h0);
    chk("r_dout", DOUT, 64'h0);
    chk("r_len", 64'(INFO_LEN), 64'h0);
    chk("r_ts", 64'(INFO_TIMESTAMP), 64'h0);
    chk("r_drop", 64'(DROP_CNT), 64'h0);
    tick();
    RESETN = 1'b1;
    txq = '{hdr(8'h00, 24'h111111, 8'd1), 64'hF2, ftr(8'h00, 24'h222222, 8'd1)};
    run(1'b0, 6);
    chk("r_after_beats", 64'(rxData.size()), 64'd1);
    chk("r_after_info", 64'(infoCnt), 64'd1);
    chk("r_after_ts", 64'(INFO_TIMESTAMP), 64'h0000_1111_1122_2222);
    chk("r_after_errs", 64'(errH + errF), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
